// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target (slave) with an auto-incrementing register file.
//
// The host addresses the device (DEV_ADDR), writes a sub-address byte, then either
// writes a burst of data bytes or issues a repeated START and reads a burst back.
// The sub-address wraps modulo NUM_REGS on every byte transferred.
//
// Ports:
//   clk       system clock, at least 16x the SCL rate
//   rst       synchronous active-high reset
//   scl_in    SCL pad input (asynchronous)
//   sda_in    SDA pad input (asynchronous)
//   sda_oe    1 = pull SDA low (pad output data is tied 0)
//   regs_q    flattened register file, register k at [8k+7:8k]
//   wr_pulse  one-cycle strobe per register write
//   wr_addr   register index written, valid with wr_pulse
//   busy      high from an addressed START until STOP / START / NAK exit
//
// Optional feature (macro I2C_WRITE_PROTECT_EN): register NUM_REGS-1 is a write-protect
// key. Registers 0..NUM_REGS-2 accept writes only while the key equals 8'hA5. Protected
// writes are still ACKed and still advance the sub-address. The key is always writable.

module i2c_target_regfile #(
    parameter logic [6:0]  DEV_ADDR    = 7'h70,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         scl_in,
    input  logic                         sda_in,
    output logic                         sda_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_q,
    output logic                         wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0]  wr_addr,
    output logic                         busy
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StSub,
        StSubAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronisers plus one history flop per line
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync_d, scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_d, sda_sync_q;
    logic                   scl_prev_d, scl_prev_q;
    logic                   sda_prev_d, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // The synchronisers are deliberately not reset: clearing them mid-transfer could
    // fabricate a START/STOP edge from a stale sample.
    always_ff @(posedge clk) begin
        scl_sync_q <= scl_sync_d;
        sda_sync_q <= sda_sync_d;
        scl_prev_q <= scl_prev_d;
        sda_prev_q <= sda_prev_d;
    end

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    // SDA may only change while SCL is high for START/STOP; SCL must be high on both samples.
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_e              state_d, state_q;
    logic [3:0]          bit_cnt_d, bit_cnt_q;
    logic [DATA_W-1:0]   shreg_d, shreg_q;
    logic [AW-1:0]       sub_d, sub_q;
    logic                rw_d, rw_q;
    logic                sda_oe_d, sda_oe_q;
    logic                busy_d, busy_q;
    logic                wr_pulse_d, wr_pulse_q;
    logic [AW-1:0]       wr_addr_d, wr_addr_q;

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic                mem_we;
    logic                wr_ok;
    logic [DATA_W-1:0]   rd_byte;

    assign rd_byte = mem_q[sub_q];

`ifdef I2C_WRITE_PROTECT_EN
    assign wr_ok = (sub_q == AW'(NUM_REGS - 1)) || (mem_q[NUM_REGS-1] == DATA_W'(8'hA5));
`else
    assign wr_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        sub_d      = sub_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        mem_we     = 1'b0;

        if (start_det) begin
            // Any START (first or repeated) restarts address reception.
            state_d   = StAddr;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end

                StAddr, StSub, StWdata: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shreg_d   = {shreg_q[DATA_W-2:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == StAddr) begin
                            if (shreg_q[7:1] == DEV_ADDR) begin
                                rw_d     = shreg_q[0];
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                                state_d  = StAddrAck;
                            end else begin
                                state_d = StIdle;
                            end
                        end else if (state_q == StSub) begin
                            // Upper bits of the sub byte are only range-checked.
                            if (32'(shreg_q) < NUM_REGS) begin
                                sub_d    = shreg_q[AW-1:0];
                                sda_oe_d = 1'b1;
                                state_d  = StSubAck;
                            end else begin
                                sda_oe_d = 1'b0;
                                busy_d   = 1'b0;
                                state_d  = StIdle;
                            end
                        end else begin
                            if (wr_ok) begin
                                mem_we     = 1'b1;
                                wr_pulse_d = 1'b1;
                                wr_addr_d  = sub_q;
                            end
                            sub_d    = sub_q + AW'(1);
                            sda_oe_d = 1'b1;
                            state_d  = StWdataAck;
                        end
                    end
                end

                StAddrAck: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            // Read: present bit 7 on the same edge that ends the ACK.
                            shreg_d  = rd_byte;
                            sda_oe_d = ~rd_byte[DATA_W-1];
                            state_d  = StRdata;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = StSub;
                        end
                    end
                end

                StSubAck, StWdataAck: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = StWdata;
                    end
                end

                StRdata: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            sub_d     = sub_q + AW'(1);
                            bit_cnt_d = 4'd0;
                            state_d   = StRdataAck;
                        end else begin
                            shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
                            sda_oe_d = ~shreg_q[DATA_W-2];
                        end
                    end
                end

                StRdataAck: begin
                    // bit_cnt_q == 1 marks "controller ACKed, send next byte on fall".
                    if (scl_rise) begin
                        if (sda_s) begin
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                            state_d  = StIdle;
                        end else begin
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        shreg_d   = rd_byte;
                        sda_oe_d  = ~rd_byte[DATA_W-1];
                        bit_cnt_d = 4'd0;
                        state_d   = StRdata;
                    end
                end

                default: begin
                    state_d  = StIdle;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 4'd0;
            shreg_q    <= '0;
            sub_q      <= '0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            sub_q      <= sub_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                mem_q[k] <= '0;
            end
        end else if (mem_we) begin
            mem_q[sub_q] <= shreg_q;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_flat
        assign regs_q[k*DATA_W +: DATA_W] = mem_q[k];
    end

    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Scoreboard bench for i2c_target_regfile: a bus-level I2C controller model drives
// SCL/SDA; expected register writes are queued as stimulus is issued and a separate
// monitor pops them whenever the DUT strobes wr_pulse.

module tb_i2c_target_regfile;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         scl = 1'b1;
    logic         sda_drv = 1'b1;
    wire          sda_line;
    logic         sda_oe;
    logic [127:0] regs_q;
    logic         wr_pulse;
    logic [3:0]   wr_addr;
    logic         busy;

    // Open-drain bus: line is low if either side pulls it.
    assign sda_line = sda_drv & ~sda_oe;

    i2c_target_regfile #(
        .DEV_ADDR    (7'h70),
        .NUM_REGS    (16),
        .DATA_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .regs_q   (regs_q),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] model [16];
    int         n_pass = 0;
    int         n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] model_image();
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[k*8 +: 8] = model[k];
        return v;
    endfunction

    // Monitor: each write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && wr_pulse) begin
            if (exp_q.size() == 0) begin
                check("unexpected wr_pulse addr", {124'd0, wr_addr}, 128'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {124'd0, wr_addr}, {124'd0, e.addr});
                check("wr data", {120'd0, regs_q[e.addr*8 +: 8]}, {120'd0, e.data});
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    // One quarter SCL period = 8 clk (SCL period = 32 clk).
    task automatic q();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; q();
        scl = 1'b1;     q();
        sda_drv = 1'b0; q();
        scl = 1'b0;     q();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; q();
        scl = 1'b1;     q();
        sda_drv = 1'b1; q();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic write_bit(input logic b);
        sda_drv = b; q();
        scl = 1'b1;  q(); q();
        scl = 1'b0;  q();
    endtask

    task automatic read_bit(output logic b);
        sda_drv = 1'b1; q();
        scl = 1'b1;     q();
        b = sda_line;   q();
        scl = 1'b0;     q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(r);
        ack = ~r;
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic host_ack);
        for (int i = 7; i >= 0; i--) read_bit(b[i]);
        write_bit(~host_ack);
    endtask

    // Queue an expected write if the target should accept it.
    task automatic expect_write(input logic [3:0] a, input logic [7:0] d);
        logic allowed;
        allowed = 1'b1;
`ifdef I2C_WRITE_PROTECT_EN
        allowed = (a == 4'd15) || (model[15] == 8'hA5);
`endif
        if (allowed) begin
            exp_q.push_back('{addr: a, data: d});
            model[a] = d;
        end
    endtask

    // Write burst helper: addr+W, sub, then data bytes with auto-increment.
    task automatic write_txn(input string tag, input logic [3:0] sub, input logic [7:0] d0,
                             input logic [7:0] d1, input int n);
        logic ack;
        i2c_start();
        send_byte(8'hE0, ack); check({tag, " addr ack"}, ack, 1'b1);
        send_byte({4'd0, sub}, ack); check({tag, " sub ack"}, ack, 1'b1);
        expect_write(sub, d0);
        send_byte(d0, ack); check({tag, " d0 ack"}, ack, 1'b1);
        if (n > 1) begin
            expect_write(sub + 4'd1, d1);
            send_byte(d1, ack); check({tag, " d1 ack"}, ack, 1'b1);
        end
        i2c_stop();
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;
        for (int k = 0; k < 16; k++) model[k] = 8'h00;

        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("reset sda_oe", sda_oe, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset wr_pulse", wr_pulse, 1'b0);
        check("reset wr_addr", wr_addr, 4'd0);
        check("reset regs", regs_q, 128'd0);

        // Write 0x55, 0x1F from sub 10, with busy observed mid-transaction.
        i2c_start();
        send_byte(8'hE0, ack); check("t1 addr ack", ack, 1'b1);
        check("t1 busy high", busy, 1'b1);
        send_byte(8'd10, ack); check("t1 sub ack", ack, 1'b1);
        expect_write(4'd10, 8'h55);
        send_byte(8'h55, ack); check("t1 d0 ack", ack, 1'b1);
        expect_write(4'd11, 8'h1F);
        send_byte(8'h1F, ack); check("t1 d1 ack", ack, 1'b1);
        i2c_stop();
        check("t1 busy after stop", busy, 1'b0);
        check("t1 regs", regs_q, model_image());

        // Wrong device address: no ACK, no busy, nothing written.
        i2c_start();
        send_byte(8'hE2, ack); check("t2 addr nak", ack, 1'b0);
        check("t2 busy low", busy, 1'b0);
        send_byte(8'd3, ack); check("t2 sub ignored", ack, 1'b0);
        i2c_stop();
        check("t2 regs", regs_q, model_image());

        // Sub-address wrap 15 -> 0, then out-of-range sub-address.
        write_txn("t3", 4'd15, 8'hAA, 8'hBB, 2);
        check("t3 regs wrap", regs_q, model_image());
        i2c_start();
        send_byte(8'hE0, ack); check("t3b addr ack", ack, 1'b1);
        send_byte(8'd16, ack); check("t3b sub nak", ack, 1'b0);
        check("t3b busy after nak", busy, 1'b0);
        send_byte(8'h77, ack); check("t3b data ignored", ack, 1'b0);
        i2c_stop();
        check("t3b regs", regs_q, model_image());

        // Combined write-sub / repeated START / read two bytes.
        i2c_start();
        send_byte(8'hE0, ack); check("t4 addr ack", ack, 1'b1);
        send_byte(8'd10, ack); check("t4 sub ack", ack, 1'b1);
        i2c_start();
        send_byte(8'hE1, ack); check("t4 raddr ack", ack, 1'b1);
        recv_byte(rb, 1'b1); check("t4 rd0", rb, model[10]);
        recv_byte(rb, 1'b0); check("t4 rd1", rb, model[11]);
        check("t4 sda released after nak", sda_oe, 1'b0);
        check("t4 busy after nak", busy, 1'b0);
        i2c_stop();

        // Reset during the 4th data bit of a write.
        i2c_start();
        send_byte(8'hE0, ack); check("t5 addr ack", ack, 1'b1);
        send_byte(8'd5, ack); check("t5 sub ack", ack, 1'b1);
        write_bit(1'b1); write_bit(1'b1); write_bit(1'b1);
        sda_drv = 1'b1; q();
        scl = 1'b1; q();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) model[k] = 8'h00;
        check("t5 rst sda_oe", sda_oe, 1'b0);
        check("t5 rst busy", busy, 1'b0);
        check("t5 rst regs", regs_q, 128'd0);
        rst = 1'b0;
        q();
        scl = 1'b0; q();
        i2c_stop();
        write_txn("t5b", 4'd2, 8'h3C, 8'h00, 1);
        check("t5b regs", regs_q, model_image());

`ifdef I2C_WRITE_PROTECT_EN
        // Key register 15 is 0: write to reg 3 is ACKed but dropped.
        write_txn("t6a", 4'd3, 8'h12, 8'h00, 1);
        check("t6a regs protected", regs_q, model_image());
        write_txn("t6b", 4'd15, 8'hA5, 8'h00, 1);
        write_txn("t6c", 4'd3, 8'h12, 8'h00, 1);
        check("t6c regs unlocked", regs_q, model_image());
`endif

        repeat (10) @(posedge clk);
        #1;
        check("pending writes", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
